// File: rtl/stream_record_extractor.sv
// stream_record_extractor: one element of a token ring sharing a byte bus.
// Captures a single variable-length, delimiter-terminated record followed by
// a fixed-length field. Aligns the record to byte 0 and offers it on a
// valid/ready output.
module stream_record_extractor #(
   parameter int BUS_BYTES             = 8,
   parameter int MAX_VAR_BYTES         = 16,
   parameter int FIXED_BYTES           = 17,
   parameter int MY_ID                 = 0,
   parameter int RESET_TOKEN_HOLDER_ID = 0,
   localparam int REC_MAX = MAX_VAR_BYTES + 1 + FIXED_BYTES,
   localparam int BUF     = REC_MAX + BUS_BYTES,
   localparam int OFF_W   = $clog2(BUS_BYTES),
   localparam int LEN_W   = $clog2(REC_MAX + 1)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [7:0]             delimiter,
   input  logic [BUS_BYTES*8-1:0] dataIn,
   input  logic                   dataInValid,
   input  logic                   tokenIn,
   input  logic [OFF_W-1:0]       firstByteOffsetIn,
   output logic                   tokenOut,
   output logic [OFF_W-1:0]       firstByteOffsetOut,
   output logic [REC_MAX*8-1:0]   recOut,
   output logic [LEN_W-1:0]       recLength,
   output logic                   recValid,
   input  logic                   recReady,
   output logic                   recError,
   output logic                   overrun
);

   localparam int CNT_W     = $clog2(BUF / BUS_BYTES + 1);
   localparam int NBANK     = (BUF + BUS_BYTES - 1) / BUS_BYTES;
   localparam int BUF_BYTES = NBANK * BUS_BYTES;

   typedef enum logic [1:0] {IDLE, FILL, ALIGN, HOLD} stateType;

   stateType               state, stateNext;
   logic                   token;
   logic [CNT_W-1:0]       cnt;
   logic [OFF_W-1:0]       startOff;
   logic [BUF_BYTES*8-1:0] bufMem, bufNext;
   logic [LEN_W-1:0]       lenReg;
   logic                   errReg;

   logic                   handshake, accept, own, latch, shadow;
   logic [OFF_W-1:0]       offEff;
   logic [CNT_W-1:0]       wrBank;
   int                     filled, pos, delimPos;
   logic                   found, errNow, complete;
   logic [LEN_W-1:0]       lenNow;
   logic [LEN_W:0]         endPos;
   logic [REC_MAX*8-1:0]   alignRec;

   // Ownership, bank selection, delimiter search and completion for the
   // buffer as it will look after this cycle's write.
   always_comb begin
      handshake = recValid & recReady;
      accept    = tokenIn & ((state == IDLE) | ((state == HOLD) & handshake));
      own       = token | tokenIn;
      latch     = dataInValid & ((state == FILL) | ((state == IDLE) & own) | ((state == HOLD) & accept));
      shadow    = dataInValid & ~own & ((state == IDLE) | (state == HOLD));
      offEff    = accept ? firstByteOffsetIn : startOff;
      if (shadow)
         wrBank = '0;
      else if (accept)
         wrBank = CNT_W'(firstByteOffsetIn != '0);
      else
         wrBank = cnt;
      bufNext = bufMem;
      if (latch | shadow)
         bufNext[int'(wrBank)*BUS_BYTES*8 +: BUS_BYTES*8] = dataIn;
      filled   = (int'(wrBank) + 1) * BUS_BYTES;
      found    = 1'b0;
      delimPos = 0;
      pos      = 0;
      for (int unsigned i = 0; i <= MAX_VAR_BYTES; i++) begin
         pos = int'(offEff) + int'(i);
         if (!found && (pos < filled) && (bufNext[pos*8 +: 8] == delimiter)) begin
            found    = 1'b1;
            delimPos = pos;
         end
      end
      errNow   = ~found & ((int'(offEff) + MAX_VAR_BYTES) < filled);
      lenNow   = found ? LEN_W'(delimPos - int'(offEff) + 1 + FIXED_BYTES) : LEN_W'(REC_MAX);
      endPos   = (LEN_W+1)'(offEff) + (LEN_W+1)'(lenNow);
      complete = latch & (found | errNow) & (int'(endPos) <= filled);
   end

   // Barrel shift: record byte i comes from buffer byte startOff+i.
   always_comb begin
      alignRec = '0;
      for (int unsigned i = 0; i < REC_MAX; i++)
         alignRec[i*8 +: 8] = bufMem[(int'(startOff) + int'(i))*8 +: 8];
   end

   // Next-state decode.
   always_comb begin
      stateNext = state;
      case (state)
         IDLE:  if (latch) stateNext = complete ? ALIGN : FILL;
         FILL:  if (complete) stateNext = ALIGN;
         ALIGN: stateNext = HOLD;
         HOLD: begin
            if (handshake) begin
               if (latch)
                  stateNext = complete ? ALIGN : FILL;
               else
                  stateNext = IDLE;
            end
         end
         default: stateNext = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         state <= IDLE;
      else
         state <= stateNext;
   end

   // Token, buffer, counters, record outputs and the sticky overrun flag.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         token              <= (MY_ID == RESET_TOKEN_HOLDER_ID);
         cnt                <= '0;
         startOff           <= '0;
         bufMem             <= '0;
         lenReg             <= '0;
         errReg             <= 1'b0;
         tokenOut           <= 1'b0;
         firstByteOffsetOut <= '0;
         recOut             <= '0;
         recLength          <= '0;
         recValid           <= 1'b0;
         recError           <= 1'b0;
         overrun            <= 1'b0;
      end else begin
         tokenOut <= 1'b0;
         bufMem   <= bufNext;
         if (tokenIn & ~accept)
            overrun <= 1'b1;
         if (accept) begin
            token    <= 1'b1;
            startOff <= firstByteOffsetIn;
         end
         if (latch)
            cnt <= wrBank + CNT_W'(1);
         else if (accept)
            cnt <= wrBank;
         else if (handshake)
            cnt <= '0;
         if (complete) begin
            token              <= 1'b0;
            tokenOut           <= 1'b1;
            firstByteOffsetOut <= endPos[OFF_W-1:0];
            lenReg             <= lenNow;
            errReg             <= errNow;
         end
         if (state == ALIGN) begin
            recOut    <= alignRec;
            recLength <= lenReg;
            recError  <= errReg;
            recValid  <= 1'b1;
         end else if (handshake) begin
            recValid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_stream_record_extractor.sv
// Directed bench for stream_record_extractor at 8-, 4- and 16-byte bus widths.
module tb_stream_record_extractor;

   logic         clk, reset;
   logic [7:0]   delim;

   logic [63:0]  d8;
   logic         v8, tin8, rr8, tout8, rv8, err8, ovr8;
   logic [2:0]   off8, foo8;
   logic [271:0] rec8;
   logic [5:0]   len8;

   logic         tin8n, rr8n, tout8n, rv8n, err8n, ovr8n;
   logic [2:0]   off8n, foo8n;
   logic [271:0] rec8n;
   logic [5:0]   len8n;

   logic [31:0]  d4;
   logic         v4, tin4, rr4, tout4, rv4, err4, ovr4;
   logic [1:0]   off4, foo4;
   logic [271:0] rec4;
   logic [5:0]   len4;

   logic [127:0] d16;
   logic         v16, tin16, rr16, tout16, rv16, err16, ovr16;
   logic [3:0]   off16, foo16;
   logic [271:0] rec16;
   logic [5:0]   len16;

   logic [7:0]   strm [0:63];
   int           nChecks = 0;
   int           nFail   = 0;

   stream_record_extractor #(.BUS_BYTES(8), .MY_ID(0), .RESET_TOKEN_HOLDER_ID(0)) dut8 (
      .clk(clk), .reset(reset), .delimiter(delim), .dataIn(d8), .dataInValid(v8),
      .tokenIn(tin8), .firstByteOffsetIn(off8), .tokenOut(tout8), .firstByteOffsetOut(foo8),
      .recOut(rec8), .recLength(len8), .recValid(rv8), .recReady(rr8), .recError(err8), .overrun(ovr8));

   stream_record_extractor #(.BUS_BYTES(8), .MY_ID(1), .RESET_TOKEN_HOLDER_ID(0)) dut8n (
      .clk(clk), .reset(reset), .delimiter(delim), .dataIn(d8), .dataInValid(v8),
      .tokenIn(tin8n), .firstByteOffsetIn(off8n), .tokenOut(tout8n), .firstByteOffsetOut(foo8n),
      .recOut(rec8n), .recLength(len8n), .recValid(rv8n), .recReady(rr8n), .recError(err8n), .overrun(ovr8n));

   stream_record_extractor #(.BUS_BYTES(4), .MY_ID(0), .RESET_TOKEN_HOLDER_ID(0)) dut4 (
      .clk(clk), .reset(reset), .delimiter(delim), .dataIn(d4), .dataInValid(v4),
      .tokenIn(tin4), .firstByteOffsetIn(off4), .tokenOut(tout4), .firstByteOffsetOut(foo4),
      .recOut(rec4), .recLength(len4), .recValid(rv4), .recReady(rr4), .recError(err4), .overrun(ovr4));

   stream_record_extractor #(.BUS_BYTES(16), .MY_ID(0), .RESET_TOKEN_HOLDER_ID(0)) dut16 (
      .clk(clk), .reset(reset), .delimiter(delim), .dataIn(d16), .dataInValid(v16),
      .tokenIn(tin16), .firstByteOffsetIn(off16), .tokenOut(tout16), .firstByteOffsetOut(foo16),
      .recOut(rec16), .recLength(len16), .recValid(rv16), .recReady(rr16), .recError(err16), .overrun(ovr16));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // kind 1: 6 var bytes, ',' at 6, fixed bytes after (24-byte record at offset 0)
   // kind 2: ',' at byte 8 (record from lane 3 is 23 bytes)
   // kind 3: no delimiter anywhere
   task automatic load_stream(input int kind);
      for (int p = 0; p < 64; p++) begin
         case (kind)
            1: strm[p] = (p < 6) ? 8'(8'h41 + p) : (p == 6) ? 8'h2c : 8'(8'h60 + p);
            2: strm[p] = (p < 8) ? 8'(8'h90 + p) : (p == 8) ? 8'h2c : 8'(8'ha0 + p);
            default: strm[p] = 8'(8'h30 + p);
         endcase
      end
   endtask

   function automatic logic [271:0] exp_rec(input int start, input int len);
      logic [271:0] r;
      r = '0;
      for (int i = 0; i < len; i++) r[i*8 +: 8] = strm[start + i];
      return r;
   endfunction

   function automatic logic [271:0] rec_mask(input int len);
      logic [271:0] m;
      m = '0;
      for (int i = 0; i < len; i++) m[i*8 +: 8] = 8'hff;
      return m;
   endfunction

   task automatic put8(input int b);
      for (int j = 0; j < 8; j++) d8[j*8 +: 8] = strm[b*8 + j];
   endtask

   task automatic test_reset();
      reset = 1'b0;
      #1;
      nChecks++; if (tout8 !== 1'b0) begin nFail++; $display("FAIL reset_tokenOut got=%0h exp=0", tout8); end
      nChecks++; if (foo8 !== 3'd0) begin nFail++; $display("FAIL reset_offOut got=%0h exp=0", foo8); end
      nChecks++; if (len8 !== 6'd0) begin nFail++; $display("FAIL reset_recLength got=%0h exp=0", len8); end
      nChecks++; if (rv8 !== 1'b0) begin nFail++; $display("FAIL reset_recValid got=%0h exp=0", rv8); end
      nChecks++; if (err8 !== 1'b0) begin nFail++; $display("FAIL reset_recError got=%0h exp=0", err8); end
      nChecks++; if (ovr8 !== 1'b0) begin nFail++; $display("FAIL reset_overrun got=%0h exp=0", ovr8); end
      step();
      step();
      reset = 1'b1;
      step();
   endtask

   task automatic test_basic8();
      load_stream(1);
      v8 = 1'b1;
      for (int b = 0; b < 3; b++) begin
         put8(b);
         step();
         if (b < 2) begin
            nChecks++; if (tout8 !== 1'b0) begin nFail++; $display("FAIL basic8_tokenOut_early beat=%0d got=%0h exp=0", b, tout8); end
         end
      end
      v8 = 1'b0;
      nChecks++; if (tout8 !== 1'b1) begin nFail++; $display("FAIL basic8_tokenOut got=%0h exp=1", tout8); end
      nChecks++; if (foo8 !== 3'd0) begin nFail++; $display("FAIL basic8_offOut got=%0h exp=0", foo8); end
      nChecks++; if (rv8 !== 1'b0) begin nFail++; $display("FAIL basic8_recValid_early got=%0h exp=0", rv8); end
      step();
      nChecks++; if (tout8 !== 1'b0) begin nFail++; $display("FAIL basic8_tokenOut_pulse got=%0h exp=0", tout8); end
      nChecks++; if (rv8 !== 1'b1) begin nFail++; $display("FAIL basic8_recValid got=%0h exp=1", rv8); end
      nChecks++; if (len8 !== 6'd24) begin nFail++; $display("FAIL basic8_recLength got=%0d exp=24", len8); end
      nChecks++; if (err8 !== 1'b0) begin nFail++; $display("FAIL basic8_recError got=%0h exp=0", err8); end
      nChecks++; if (rec8[55:48] !== 8'h2c) begin nFail++; $display("FAIL basic8_delimByte got=%0h exp=2c", rec8[55:48]); end
      nChecks++; if ((rec8 & rec_mask(24)) !== exp_rec(0, 24)) begin nFail++; $display("FAIL basic8_recOut got=%h exp=%h", rec8 & rec_mask(24), exp_rec(0, 24)); end
      rr8 = 1'b1;
      step();
      rr8 = 1'b0;
      nChecks++; if (rv8 !== 1'b0) begin nFail++; $display("FAIL basic8_accept got=%0h exp=0", rv8); end
   endtask

   task automatic test_shadow_offset();
      load_stream(2);
      v8 = 1'b1;
      put8(0);
      step();
      tin8 = 1'b1;
      off8 = 3'd3;
      put8(1);
      step();
      tin8 = 1'b0;
      off8 = 3'd0;
      put8(2);
      step();
      put8(3);
      step();
      v8 = 1'b0;
      nChecks++; if (tout8 !== 1'b1) begin nFail++; $display("FAIL shadow_tokenOut got=%0h exp=1", tout8); end
      nChecks++; if (foo8 !== 3'd2) begin nFail++; $display("FAIL shadow_offOut got=%0h exp=2", foo8); end
      step();
      nChecks++; if (rv8 !== 1'b1) begin nFail++; $display("FAIL shadow_recValid got=%0h exp=1", rv8); end
      nChecks++; if (len8 !== 6'd23) begin nFail++; $display("FAIL shadow_recLength got=%0d exp=23", len8); end
      nChecks++; if (rec8[7:0] !== 8'h93) begin nFail++; $display("FAIL shadow_firstByte got=%0h exp=93", rec8[7:0]); end
      nChecks++; if ((rec8 & rec_mask(23)) !== exp_rec(3, 23)) begin nFail++; $display("FAIL shadow_recOut got=%h exp=%h", rec8 & rec_mask(23), exp_rec(3, 23)); end
      rr8 = 1'b1;
      step();
      rr8 = 1'b0;
   endtask

   task automatic test_error_hold();
      load_stream(3);
      v8 = 1'b1;
      put8(0);
      step();
      tin8 = 1'b1;
      off8 = 3'd5;
      put8(1);
      step();
      tin8 = 1'b0;
      off8 = 3'd0;
      for (int b = 2; b < 5; b++) begin
         put8(b);
         step();
      end
      v8 = 1'b0;
      nChecks++; if (tout8 !== 1'b1) begin nFail++; $display("FAIL error_tokenOut got=%0h exp=1", tout8); end
      nChecks++; if (foo8 !== 3'd7) begin nFail++; $display("FAIL error_offOut got=%0h exp=7", foo8); end
      step();
      for (int k = 0; k <= 10; k++) begin
         nChecks++; if (rv8 !== 1'b1) begin nFail++; $display("FAIL hold_recValid cyc=%0d got=%0h exp=1", k, rv8); end
         nChecks++; if (err8 !== 1'b1) begin nFail++; $display("FAIL hold_recError cyc=%0d got=%0h exp=1", k, err8); end
         nChecks++; if (len8 !== 6'd34) begin nFail++; $display("FAIL hold_recLength cyc=%0d got=%0d exp=34", k, len8); end
         nChecks++; if (rec8 !== exp_rec(5, 34)) begin nFail++; $display("FAIL hold_recOut cyc=%0d got=%h exp=%h", k, rec8, exp_rec(5, 34)); end
         if (k < 10) step();
      end
      rr8 = 1'b1;
      step();
      rr8 = 1'b0;
      nChecks++; if (rv8 !== 1'b0) begin nFail++; $display("FAIL hold_accept got=%0h exp=0", rv8); end
   endtask

   task automatic test_overrun();
      load_stream(1);
      v8 = 1'b1;
      tin8 = 1'b1;
      off8 = 3'd0;
      put8(0);
      step();
      nChecks++; if (ovr8 !== 1'b0) begin nFail++; $display("FAIL overrun_idle_token got=%0h exp=0", ovr8); end
      put8(1);
      step();
      tin8 = 1'b0;
      nChecks++; if (ovr8 !== 1'b1) begin nFail++; $display("FAIL overrun_set got=%0h exp=1", ovr8); end
      put8(2);
      step();
      v8 = 1'b0;
      nChecks++; if (tout8 !== 1'b1) begin nFail++; $display("FAIL overrun_tokenOut got=%0h exp=1", tout8); end
      step();
      nChecks++; if (len8 !== 6'd24) begin nFail++; $display("FAIL overrun_recLength got=%0d exp=24", len8); end
      nChecks++; if ((rec8 & rec_mask(24)) !== exp_rec(0, 24)) begin nFail++; $display("FAIL overrun_recOut got=%h exp=%h", rec8 & rec_mask(24), exp_rec(0, 24)); end
      rr8 = 1'b1;
      step();
      rr8 = 1'b0;
      nChecks++; if (ovr8 !== 1'b1) begin nFail++; $display("FAIL overrun_sticky got=%0h exp=1", ovr8); end
   endtask

   task automatic test_reset_mid_fill();
      load_stream(1);
      v8 = 1'b1;
      tin8 = 1'b1;
      put8(0);
      step();
      tin8 = 1'b0;
      put8(1);
      #2;
      reset = 1'b0;
      #1;
      nChecks++; if (ovr8 !== 1'b0) begin nFail++; $display("FAIL midreset_overrun got=%0h exp=0", ovr8); end
      nChecks++; if (len8 !== 6'd0) begin nFail++; $display("FAIL midreset_recLength got=%0d exp=0", len8); end
      nChecks++; if (rv8 !== 1'b0) begin nFail++; $display("FAIL midreset_recValid got=%0h exp=0", rv8); end
      nChecks++; if (tout8 !== 1'b0) begin nFail++; $display("FAIL midreset_tokenOut got=%0h exp=0", tout8); end
      v8 = 1'b0;
      step();
      reset = 1'b1;
      step();
      v8 = 1'b1;
      for (int b = 0; b < 3; b++) begin
         put8(b);
         step();
         nChecks++; if (tout8n !== 1'b0) begin nFail++; $display("FAIL nonholder_tokenOut beat=%0d got=%0h exp=0", b, tout8n); end
      end
      v8 = 1'b0;
      nChecks++; if (tout8 !== 1'b1) begin nFail++; $display("FAIL holder_tokenOut got=%0h exp=1", tout8); end
      step();
      nChecks++; if (rv8 !== 1'b1) begin nFail++; $display("FAIL holder_recValid got=%0h exp=1", rv8); end
      nChecks++; if (len8 !== 6'd24) begin nFail++; $display("FAIL holder_recLength got=%0d exp=24", len8); end
      nChecks++; if (rv8n !== 1'b0) begin nFail++; $display("FAIL nonholder_recValid got=%0h exp=0", rv8n); end
      nChecks++; if ({len8n, foo8n, err8n, ovr8n} !== 11'd0) begin nFail++; $display("FAIL nonholder_outputs got=%0h exp=0", {len8n, foo8n, err8n, ovr8n}); end
      nChecks++; if (rec8n !== '0) begin nFail++; $display("FAIL nonholder_recOut got=%h exp=0", rec8n); end
      rr8 = 1'b1;
      step();
      rr8 = 1'b0;
   endtask

   task automatic test_widths();
      load_stream(1);
      v4 = 1'b1;
      for (int b = 0; b < 6; b++) begin
         for (int j = 0; j < 4; j++) d4[j*8 +: 8] = strm[b*4 + j];
         step();
      end
      v4 = 1'b0;
      nChecks++; if (tout4 !== 1'b1) begin nFail++; $display("FAIL bus4_tokenOut got=%0h exp=1", tout4); end
      nChecks++; if (foo4 !== 2'd0) begin nFail++; $display("FAIL bus4_offOut got=%0h exp=0", foo4); end
      step();
      nChecks++; if (rv4 !== 1'b1) begin nFail++; $display("FAIL bus4_recValid got=%0h exp=1", rv4); end
      nChecks++; if (len4 !== 6'd24) begin nFail++; $display("FAIL bus4_recLength got=%0d exp=24", len4); end
      nChecks++; if ({err4, ovr4} !== 2'b00) begin nFail++; $display("FAIL bus4_flags got=%0h exp=0", {err4, ovr4}); end
      nChecks++; if ((rec4 & rec_mask(24)) !== exp_rec(0, 24)) begin nFail++; $display("FAIL bus4_recOut got=%h exp=%h", rec4 & rec_mask(24), exp_rec(0, 24)); end
      rr4 = 1'b1;
      step();
      rr4 = 1'b0;
      nChecks++; if (rv4 !== 1'b0) begin nFail++; $display("FAIL bus4_accept got=%0h exp=0", rv4); end

      v16 = 1'b1;
      for (int b = 0; b < 2; b++) begin
         for (int j = 0; j < 16; j++) d16[j*8 +: 8] = strm[b*16 + j];
         step();
      end
      v16 = 1'b0;
      nChecks++; if (tout16 !== 1'b1) begin nFail++; $display("FAIL bus16_tokenOut got=%0h exp=1", tout16); end
      nChecks++; if (foo16 !== 4'd8) begin nFail++; $display("FAIL bus16_offOut got=%0h exp=8", foo16); end
      step();
      nChecks++; if (rv16 !== 1'b1) begin nFail++; $display("FAIL bus16_recValid got=%0h exp=1", rv16); end
      nChecks++; if (len16 !== 6'd24) begin nFail++; $display("FAIL bus16_recLength got=%0d exp=24", len16); end
      nChecks++; if ({err16, ovr16} !== 2'b00) begin nFail++; $display("FAIL bus16_flags got=%0h exp=0", {err16, ovr16}); end
      nChecks++; if ((rec16 & rec_mask(24)) !== exp_rec(0, 24)) begin nFail++; $display("FAIL bus16_recOut got=%h exp=%h", rec16 & rec_mask(24), exp_rec(0, 24)); end
      rr16 = 1'b1;
      step();
      rr16 = 1'b0;
      nChecks++; if (rv16 !== 1'b0) begin nFail++; $display("FAIL bus16_accept got=%0h exp=0", rv16); end
   endtask

   initial begin
      reset = 1'b0;
      delim = 8'h2c;
      d8 = '0;  v8 = 1'b0;  tin8 = 1'b0;  off8 = '0;  rr8 = 1'b0;
      tin8n = 1'b0;  off8n = '0;  rr8n = 1'b1;
      d4 = '0;  v4 = 1'b0;  tin4 = 1'b0;  off4 = '0;  rr4 = 1'b0;
      d16 = '0; v16 = 1'b0; tin16 = 1'b0; off16 = '0; rr16 = 1'b0;
      #3;
      test_reset();
      test_basic8();
      test_shadow_offset();
      test_error_hold();
      test_overrun();
      test_reset_mid_fill();
      test_widths();
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

endmodule

// File: doc/stream_record_extractor.md
Name: stream_record_extractor

Overview:
- Next-generation stream element for the AXI-Stream record compressor. Extracts one variable-plus-fixed-length record from a shared byte bus.
- Sits in a ring of N instances. A token decides which instance consumes the current beat.
- Generalised over the previous element:
  - any power-of-2 bus width;
  - runtime delimiter;
  - single-cycle barrel alignment;
  - valid/ready output;
  - missing-delimiter error and ring-overrun detection.

Parameters:
- BUS_BYTES, 8, bus width in bytes; power of 2, 2..32, must be <= FIXED_BYTES+1.
- MAX_VAR_BYTES, 16, maximum variable-field length in bytes, delimiter excluded.
- FIXED_BYTES, 17, fixed-field length after the delimiter.
- MY_ID, 0, this instance's ring index.
- RESET_TOKEN_HOLDER_ID, 0, ring index that holds the token after reset.
- Derived: REC_MAX = MAX_VAR_BYTES+1+FIXED_BYTES; BUF = REC_MAX+BUS_BYTES; OFF_W = clog2(BUS_BYTES); LEN_W = clog2(REC_MAX+1).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- delimiter  in  8  delimiter byte; quasi-static, changed only while the ring is idle
- dataIn  in  BUS_BYTES*8  shared input beat; byte 0 = earliest
- dataInValid  in  1  beat valid
- tokenIn  in  1  one-cycle token pulse from the predecessor
- firstByteOffsetIn  in  OFF_W  byte lane where this element's record starts
- tokenOut  out  1  one-cycle token pulse to the successor
- firstByteOffsetOut  out  OFF_W  start lane for the successor
- recOut  out  REC_MAX*8  aligned record; byte 0 = first record byte
- recLength  out  LEN_W  record length in bytes
- recValid  out  1  record available
- recReady  in  1  consumer accept
- recError  out  1  qualifies the record: no delimiter found within MAX_VAR_BYTES
- overrun  out  1  sticky: token arrived while busy

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, buffer, bank counter and startOff cleared.
  - token=1 iff MY_ID==RESET_TOKEN_HOLDER_ID.
  - tokenOut, recValid, recError, overrun, recLength, firstByteOffsetOut all 0.
  - Reset mid-record discards everything.
- Effective ownership: own = token | tokenIn. A beat is latched iff own & dataInValid.
- States: IDLE, FILL, ALIGN, HOLD.
- IDLE:
  - With !own, each valid beat is shadow-captured into bank 0. This preserves the predecessor's final beat when the record starts mid-beat.
  - On tokenIn: startOff <= firstByteOffsetIn.
  - If offset==0, the first owned beat goes to bank 0; otherwise bank 0 keeps the shadow and the first owned beat goes to bank 1.
  - The holder from reset uses offset 0.
  - Enter FILL on the first latched beat.
- FILL: each latched beat writes bank cnt, then cnt++.
- Delimiter search:
  - Find the lowest position p with buf[p]==delimiter and startOff <= p <= startOff+MAX_VAR_BYTES.
  - Found: len = p-startOff+1+FIXED_BYTES.
  - Not found once bytes startOff..startOff+MAX_VAR_BYTES are all present: len = REC_MAX, and error is latched.
- Completion:
  - endPos = startOff+len. The record is complete when the beat holding byte endPos-1 is latched (cycle F).
  - At F+1:
    - tokenOut=1 for exactly one cycle;
    - firstByteOffsetOut = endPos mod BUS_BYTES (held until the next completion);
    - token cleared;
    - state=ALIGN.
  - Beats at F+1 and later belong to the successor and are not written here.
- ALIGN:
  - One cycle, always, including offset 0.
  - recOut[i] <= buf[startOff+i] for i < REC_MAX; bytes at index >= len are don't-care.
  - recLength <= len, recError <= error flag; at F+2 recValid=1, state=HOLD.
- HOLD:
  - recOut, recLength and recError are stable while recValid & !recReady.
  - On recValid&recReady: recValid=0 next cycle, state=IDLE, cnt=0.
- Token arrival while busy:
  - tokenIn in FILL/ALIGN, or in HOLD without a same-cycle handshake, sets overrun (sticky); the token is dropped.
  - tokenIn in HOLD with a same-cycle handshake is accepted and proceeds as from IDLE.
- Widths:
  - endPos is computed at LEN_W+1 bits; the mod uses the low OFF_W bits.
  - cnt is sized to clog2(BUF/BUS_BYTES+1).

Test Plan:
- BUS_BYTES=8, reset holder, offset 0, 6 var bytes + ',' + 17 fixed (24B) over 3 beats.
  - Required: tokenOut 1 cycle after beat 3; firstByteOffsetOut=0; recValid 2 cycles after beat 3; recLength=24; recOut[6]=8'h2c.
- Token arrives with firstByteOffsetIn=3, record 23B.
  - Required: shadow beat used as bank 0; recOut[0] = original lane 3; firstByteOffsetOut=2; recLength=23.
- 17 non-delimiter var bytes (MAX_VAR_BYTES+1).
  - Required: recError=1, recLength=34; token passed with firstByteOffsetOut=(off+34)%8.
- recReady held low 10 cycles.
  - Required: recOut, recLength, recValid stable; accept on cycle 11; IDLE next cycle.
- tokenIn during FILL.
  - Required: overrun=1 and stays 1; no beat lost from the current record.
- Reset asserted mid-FILL, then released.
  - Required: all outputs 0 immediately; only the RESET_TOKEN_HOLDER_ID instance owns the next beat.
- Repeat the first scenario with BUS_BYTES=4 and 16.
  - Required: identical recLength and recOut.
